// File: rtl/active_list_ctrl_pkg.sv
// Shared core definitions for the active list: sizing defaults and the entry layout.
package active_list_ctrl_pkg;

  localparam int AL_DEPTH        = 32;
  localparam int AL_WB_PORTS     = 2;
  localparam int AL_COMMIT_WIDTH = 2;
  localparam int AL_PHYS_W       = 6;
  localparam int AL_IDX_W        = $clog2(AL_DEPTH);

  typedef struct packed {
    logic [31:0]          pc;
    logic                 is_load;
    logic                 is_store;
    logic                 uses_rw;
    logic [4:0]           rw_addr;
    logic [AL_PHYS_W-1:0] reclaim;
    logic                 valid;
    logic                 done;
  } active_list_entry_t;

endpackage

// File: rtl/active_list_ctrl_if.sv
// Dispatch, completion, flush and retirement signals between the pipeline and the active list.
interface active_list_ctrl_if
  import active_list_ctrl_pkg::*;
#(
  parameter int DEPTH        = AL_DEPTH,
  parameter int WB_PORTS     = AL_WB_PORTS,
  parameter int COMMIT_WIDTH = AL_COMMIT_WIDTH,
  parameter int PHYS_W       = AL_PHYS_W
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                                alloc_valid;
  logic                                alloc_ready;
  logic [IDX_W-1:0]                    alloc_id;
  logic [31:0]                         alloc_pc;
  logic                                alloc_is_load;
  logic                                alloc_is_store;
  logic                                alloc_uses_rw;
  logic [4:0]                          alloc_rw_addr;
  logic [PHYS_W-1:0]                   alloc_reclaim;

  logic [WB_PORTS-1:0]                 wb_valid;
  logic [WB_PORTS-1:0][IDX_W-1:0]      wb_id;

  logic                                branch_miss;
  logic [IDX_W-1:0]                    miss_keep_id;
  logic                                commit_hold;

  logic [COMMIT_WIDTH-1:0]             commit_valid;
  logic [COMMIT_WIDTH-1:0][31:0]       commit_pc;
  logic [COMMIT_WIDTH-1:0]             commit_is_load;
  logic [COMMIT_WIDTH-1:0]             commit_is_store;
  logic [COMMIT_WIDTH-1:0]             commit_uses_rw;
  logic [COMMIT_WIDTH-1:0][4:0]        commit_rw_addr;
  logic [COMMIT_WIDTH-1:0][PHYS_W-1:0] commit_reclaim;

  logic [IDX_W:0]                      count;
  logic                                empty;
  logic                                full;

  modport master (
    output alloc_valid, alloc_pc, alloc_is_load, alloc_is_store, alloc_uses_rw,
           alloc_rw_addr, alloc_reclaim, wb_valid, wb_id, branch_miss, miss_keep_id,
           commit_hold,
    input  alloc_ready, alloc_id, commit_valid, commit_pc, commit_is_load,
           commit_is_store, commit_uses_rw, commit_rw_addr, commit_reclaim,
           count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_is_load, alloc_is_store, alloc_uses_rw,
           alloc_rw_addr, alloc_reclaim, wb_valid, wb_id, branch_miss, miss_keep_id,
           commit_hold,
    output alloc_ready, alloc_id, commit_valid, commit_pc, commit_is_load,
           commit_is_store, commit_uses_rw, commit_rw_addr, commit_reclaim,
           count, empty, full
  );

endinterface

// File: rtl/active_list_ctrl_commit_sel.sv
// In-order retirement picker over the oldest COMMIT_WIDTH entries; at most one store per cycle.
module active_list_commit_sel #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                    commit_hold,
  input  logic [COMMIT_WIDTH-1:0] win_valid,
  input  logic [COMMIT_WIDTH-1:0] win_done,
  input  logic [COMMIT_WIDTH-1:0] win_store,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output logic [CNT_W-1:0]        commit_cnt
);

  logic chain_s;
  logic store_seen_s;

  // Walk slots oldest-first; the first ineligible slot stops everything younger.
  always_comb begin
    commit_valid = '0;
    commit_cnt   = '0;
    chain_s      = ~commit_hold;
    store_seen_s = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (chain_s && win_valid[k] && win_done[k] && !(win_store[k] && store_seen_s)) begin
        commit_valid[k] = 1'b1;
        commit_cnt      = commit_cnt + CNT_W'(1);
        store_seen_s    = store_seen_s | win_store[k];
      end else begin
        chain_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/active_list_ctrl.sv
// Active list (reorder buffer) controller: circular allocation, completion marking,
// in-order multi-wide retirement and branch-miss tail rollback.
module active_list_ctrl
  import active_list_ctrl_pkg::*;
#(
  parameter int DEPTH        = AL_DEPTH,
  parameter int WB_PORTS     = AL_WB_PORTS,
  parameter int COMMIT_WIDTH = AL_COMMIT_WIDTH,
  parameter int PHYS_W       = AL_PHYS_W
) (
  input  logic               clk,
  input  logic               rst,
  active_list_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

  active_list_entry_t      mem_r [DEPTH];
  logic [IDX_W:0]          head_r;
  logic [IDX_W:0]          tail_r;

  logic [IDX_W-1:0]        head_idx_s;
  logic [IDX_W-1:0]        tail_idx_s;
  logic [IDX_W-1:0]        keep_off_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    alloc_ready_s;
  logic                    alloc_fire_s;
  logic [COMMIT_WIDTH-1:0] win_valid_s;
  logic [COMMIT_WIDTH-1:0] win_done_s;
  logic [COMMIT_WIDTH-1:0] win_store_s;
  logic [COMMIT_WIDTH-1:0] commit_valid_s;
  logic [CNT_W-1:0]        commit_cnt_s;
  logic [DEPTH-1:0]        valid_nxt_s;
  logic [DEPTH-1:0]        done_nxt_s;
  logic [IDX_W:0]          head_nxt_s;
  logic [IDX_W:0]          tail_nxt_s;

  // Status flags derived from registered pointers only.
  always_comb begin
    head_idx_s    = head_r[IDX_W-1:0];
    tail_idx_s    = tail_r[IDX_W-1:0];
    empty_s       = (head_r == tail_r);
    full_s        = (head_idx_s == tail_idx_s) && (head_r[IDX_W] != tail_r[IDX_W]);
    alloc_ready_s = ~full_s & ~bus.branch_miss;
    alloc_fire_s  = bus.alloc_valid & alloc_ready_s;
    keep_off_s    = bus.miss_keep_id - head_idx_s;
    bus.alloc_ready = alloc_ready_s;
    bus.alloc_id    = tail_idx_s;
    bus.count       = tail_r - head_r;
    bus.empty       = empty_s;
    bus.full        = full_s;
  end

  // Present the oldest COMMIT_WIDTH entries (index wraps modulo DEPTH).
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      win_valid_s[k]         = mem_r[head_idx_s + IDX_W'(k)].valid;
      win_done_s[k]          = mem_r[head_idx_s + IDX_W'(k)].done;
      win_store_s[k]         = mem_r[head_idx_s + IDX_W'(k)].is_store;
      bus.commit_pc[k]       = mem_r[head_idx_s + IDX_W'(k)].pc;
      bus.commit_is_load[k]  = mem_r[head_idx_s + IDX_W'(k)].is_load;
      bus.commit_is_store[k] = mem_r[head_idx_s + IDX_W'(k)].is_store;
      bus.commit_uses_rw[k]  = mem_r[head_idx_s + IDX_W'(k)].uses_rw;
      bus.commit_rw_addr[k]  = mem_r[head_idx_s + IDX_W'(k)].rw_addr;
      bus.commit_reclaim[k]  = PHYS_W'(mem_r[head_idx_s + IDX_W'(k)].reclaim);
    end
    bus.commit_valid = commit_valid_s;
  end

  active_list_commit_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (CNT_W)
  ) u_commit_sel (
    .commit_hold  (bus.commit_hold),
    .win_valid    (win_valid_s),
    .win_done     (win_done_s),
    .win_store    (win_store_s),
    .commit_valid (commit_valid_s),
    .commit_cnt   (commit_cnt_s)
  );

  // Next valid/done: completion, then retirement, then flush (flush beats wb), then alloc.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_nxt_s[i] = mem_r[i].valid;
      done_nxt_s[i]  = mem_r[i].done;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      done_nxt_s[bus.wb_id[p]] = done_nxt_s[bus.wb_id[p]] | (bus.wb_valid[p] & mem_r[bus.wb_id[p]].valid);
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      valid_nxt_s[head_idx_s + IDX_W'(k)] = valid_nxt_s[head_idx_s + IDX_W'(k)] & ~commit_valid_s[k];
      done_nxt_s[head_idx_s + IDX_W'(k)]  = done_nxt_s[head_idx_s + IDX_W'(k)] & ~commit_valid_s[k];
    end
    // Age is the distance from head; anything farther than the kept entry is younger.
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.branch_miss && ((IDX_W'(i) - head_idx_s) > keep_off_s)) begin
        valid_nxt_s[i] = 1'b0;
        done_nxt_s[i]  = 1'b0;
      end else begin
        valid_nxt_s[i] = valid_nxt_s[i];
        done_nxt_s[i]  = done_nxt_s[i];
      end
    end
    valid_nxt_s[tail_idx_s] = valid_nxt_s[tail_idx_s] | alloc_fire_s;
    done_nxt_s[tail_idx_s]  = done_nxt_s[tail_idx_s] & ~alloc_fire_s;
  end

  // Pointer update; rollback rebuilds tail from head so the color bit stays consistent.
  always_comb begin
    head_nxt_s = head_r + (IDX_W+1)'(commit_cnt_s);
    if (bus.branch_miss) begin
      tail_nxt_s = head_r + {1'b0, keep_off_s} + {{IDX_W{1'b0}}, 1'b1};
    end else if (alloc_fire_s) begin
      tail_nxt_s = tail_r + {{IDX_W{1'b0}}, 1'b1};
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // State registers; payload fields are written on allocation and never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i].valid <= 1'b0;
        mem_r[i].done  <= 1'b0;
      end
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i].valid <= valid_nxt_s[i];
        mem_r[i].done  <= done_nxt_s[i];
      end
      if (alloc_fire_s) begin
        mem_r[tail_idx_s].pc       <= bus.alloc_pc;
        mem_r[tail_idx_s].is_load  <= bus.alloc_is_load;
        mem_r[tail_idx_s].is_store <= bus.alloc_is_store;
        mem_r[tail_idx_s].uses_rw  <= bus.alloc_uses_rw;
        mem_r[tail_idx_s].rw_addr  <= bus.alloc_rw_addr;
        mem_r[tail_idx_s].reclaim  <= AL_PHYS_W'(bus.alloc_reclaim);
      end else begin
        mem_r[tail_idx_s].pc <= mem_r[tail_idx_s].pc;
      end
    end
  end

endmodule

// File: tb/tb_active_list_ctrl.sv
// Directed self-checking bench for active_list_ctrl at default sizing (DEPTH=32, 2 wb, 2 commit).
module tb_active_list_ctrl;
  import active_list_ctrl_pkg::*;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  active_list_ctrl_if #(.DEPTH(DEPTH), .WB_PORTS(2), .COMMIT_WIDTH(2), .PHYS_W(6)) bus ();

  active_list_ctrl #(.DEPTH(DEPTH), .WB_PORTS(2), .COMMIT_WIDTH(2), .PHYS_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A flush may only name an entry currently in flight.
  always @(posedge clk) begin
    if (!rst && bus.branch_miss) begin
      assert ({1'b0, bus.miss_keep_id - (bus.alloc_id - bus.count[IDX_W-1:0])} < bus.count)
        else $error("illegal miss_keep_id %0d", bus.miss_keep_id);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_pc       = 32'd0;
    bus.alloc_is_load  = 1'b0;
    bus.alloc_is_store = 1'b0;
    bus.alloc_uses_rw  = 1'b0;
    bus.alloc_rw_addr  = 5'd0;
    bus.alloc_reclaim  = 6'd0;
    bus.wb_valid       = 2'b00;
    bus.wb_id[0]       = 5'd0;
    bus.wb_id[1]       = 5'd0;
    bus.branch_miss    = 1'b0;
    bus.miss_keep_id   = 5'd0;
    bus.commit_hold    = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input logic [31:0] pc, input logic st, input logic [4:0] exp_id);
    bus.alloc_valid    = 1'b1;
    bus.alloc_pc       = pc;
    bus.alloc_is_store = st;
    bus.alloc_is_load  = ~st;
    bus.alloc_uses_rw  = ~st;
    bus.alloc_rw_addr  = pc[6:2];
    bus.alloc_reclaim  = pc[7:2];
    #1;
    check_eq("alloc_id", {59'd0, bus.alloc_id}, {59'd0, exp_id});
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input logic v0, input logic [4:0] id0, input logic v1, input logic [4:0] id1);
    bus.wb_valid = {v1, v0};
    bus.wb_id[0] = id0;
    bus.wb_id[1] = id1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clr_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_empty", {63'd0, bus.empty}, 64'd1);
    check_eq("rst_full", {63'd0, bus.full}, 64'd0);
    check_eq("rst_count", {58'd0, bus.count}, 64'd0);
    check_eq("rst_ready", {63'd0, bus.alloc_ready}, 64'd1);
    check_eq("rst_cv", {62'd0, bus.commit_valid}, 64'd0);

    // Fill all 32 entries
    for (int i = 0; i < 32; i++) begin
      check_eq("fill_full_low", {63'd0, bus.full}, 64'd0);
      alloc_one(32'h1000 + 32'(i * 4), 1'b0, 5'(i));
    end
    check_eq("fill_full", {63'd0, bus.full}, 64'd1);
    check_eq("fill_ready", {63'd0, bus.alloc_ready}, 64'd0);
    check_eq("fill_count", {58'd0, bus.count}, 64'd32);

    // Two completions out of order on both ports retire together
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(32'h100 + 32'(i * 4), 1'b0, 5'(i));
    set_wb(1'b1, 5'd1, 1'b1, 5'd0);
    #1;
    check_eq("wb_cv_before", {62'd0, bus.commit_valid}, 64'd0);
    tick();
    clr_inputs();
    #1;
    check_eq("wb_cv", {62'd0, bus.commit_valid}, 64'd3);
    check_eq("wb_pc0", {32'd0, bus.commit_pc[0]}, 64'h100);
    check_eq("wb_pc1", {32'd0, bus.commit_pc[1]}, 64'h104);
    check_eq("wb_reclaim1", {58'd0, bus.commit_reclaim[1]}, 64'h01);
    tick();
    check_eq("wb_count", {58'd0, bus.count}, 64'd2);
    check_eq("wb_cv_after", {62'd0, bus.commit_valid}, 64'd0);

    // Two stores: one per cycle, plus commit_hold
    do_reset();
    alloc_one(32'h400, 1'b1, 5'd0);
    alloc_one(32'h404, 1'b1, 5'd1);
    alloc_one(32'h408, 1'b0, 5'd2);
    set_wb(1'b1, 5'd0, 1'b1, 5'd1);
    tick();
    clr_inputs();
    bus.commit_hold = 1'b1;
    #1;
    check_eq("hold_cv", {62'd0, bus.commit_valid}, 64'd0);
    tick();
    bus.commit_hold = 1'b0;
    #1;
    check_eq("st_cv0", {62'd0, bus.commit_valid}, 64'd1);
    check_eq("st_flag0", {63'd0, bus.commit_is_store[0]}, 64'd1);
    check_eq("st_pc0", {32'd0, bus.commit_pc[0]}, 64'h400);
    tick();
    check_eq("st_cv1", {62'd0, bus.commit_valid}, 64'd1);
    check_eq("st_pc1", {32'd0, bus.commit_pc[0]}, 64'h404);
    tick();
    check_eq("st_count", {58'd0, bus.count}, 64'd1);

    // Branch miss rollback keeping id 4, with alloc and wb to a flushed id
    do_reset();
    for (int i = 0; i < 10; i++) alloc_one(32'h200 + 32'(i * 4), 1'b0, 5'(i));
    bus.branch_miss  = 1'b1;
    bus.miss_keep_id = 5'd4;
    bus.alloc_valid  = 1'b1;
    bus.alloc_pc     = 32'hdead;
    set_wb(1'b1, 5'd8, 1'b0, 5'd0);
    #1;
    check_eq("bm_ready", {63'd0, bus.alloc_ready}, 64'd0);
    tick();
    clr_inputs();
    #1;
    check_eq("bm_count", {58'd0, bus.count}, 64'd5);
    check_eq("bm_alloc_id", {59'd0, bus.alloc_id}, 64'd5);
    check_eq("bm_ready_after", {63'd0, bus.alloc_ready}, 64'd1);
    set_wb(1'b1, 5'd0, 1'b1, 5'd1);
    tick();
    set_wb(1'b1, 5'd2, 1'b1, 5'd3);
    #1;
    check_eq("bm_cv_a", {62'd0, bus.commit_valid}, 64'd3);
    check_eq("bm_pc_a", {32'd0, bus.commit_pc[1]}, 64'h204);
    tick();
    set_wb(1'b1, 5'd4, 1'b0, 5'd0);
    #1;
    check_eq("bm_cv_b", {62'd0, bus.commit_valid}, 64'd3);
    check_eq("bm_pc_b", {32'd0, bus.commit_pc[0]}, 64'h208);
    tick();
    clr_inputs();
    #1;
    check_eq("bm_cv_c", {62'd0, bus.commit_valid}, 64'd1);
    check_eq("bm_pc_c", {32'd0, bus.commit_pc[0]}, 64'h210);
    tick();
    check_eq("bm_empty", {63'd0, bus.empty}, 64'd1);

    // Wrap: move head to 30, then allocate across the end of the array
    do_reset();
    for (int i = 0; i < 30; i++) alloc_one(32'h2000 + 32'(i * 4), 1'b0, 5'(i));
    for (int j = 0; j < 15; j++) begin
      set_wb(1'b1, 5'(2 * j), 1'b1, 5'(2 * j + 1));
      tick();
    end
    clr_inputs();
    tick();
    check_eq("wr_empty0", {63'd0, bus.empty}, 64'd1);
    alloc_one(32'h300, 1'b0, 5'd30);
    alloc_one(32'h304, 1'b0, 5'd31);
    alloc_one(32'h308, 1'b0, 5'd0);
    alloc_one(32'h30c, 1'b0, 5'd1);
    check_eq("wr_count", {58'd0, bus.count}, 64'd4);
    check_eq("wr_full", {63'd0, bus.full}, 64'd0);
    check_eq("wr_tail", {59'd0, bus.alloc_id}, 64'd2);
    set_wb(1'b1, 5'd30, 1'b1, 5'd31);
    tick();
    set_wb(1'b1, 5'd0, 1'b1, 5'd1);
    #1;
    check_eq("wr_cv_a", {62'd0, bus.commit_valid}, 64'd3);
    check_eq("wr_pc_a", {32'd0, bus.commit_pc[1]}, 64'h304);
    tick();
    clr_inputs();
    #1;
    check_eq("wr_cv_b", {62'd0, bus.commit_valid}, 64'd3);
    check_eq("wr_pc_b0", {32'd0, bus.commit_pc[0]}, 64'h308);
    check_eq("wr_pc_b1", {32'd0, bus.commit_pc[1]}, 64'h30c);
    tick();
    check_eq("wr_empty", {63'd0, bus.empty}, 64'd1);
    check_eq("wr_count_end", {58'd0, bus.count}, 64'd0);

    // Reset mid-operation overrides alloc, wb and branch_miss
    do_reset();
    for (int i = 0; i < 12; i++) alloc_one(32'h500 + 32'(i * 4), 1'b0, 5'(i));
    check_eq("mr_count_pre", {58'd0, bus.count}, 64'd12);
    set_wb(1'b1, 5'd0, 1'b1, 5'd1);
    bus.branch_miss  = 1'b1;
    bus.miss_keep_id = 5'd5;
    bus.alloc_valid  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_inputs();
    #1;
    check_eq("mr_empty", {63'd0, bus.empty}, 64'd1);
    check_eq("mr_count", {58'd0, bus.count}, 64'd0);
    check_eq("mr_cv", {62'd0, bus.commit_valid}, 64'd0);
    check_eq("mr_ready", {63'd0, bus.alloc_ready}, 64'd1);
    check_eq("mr_alloc_id", {59'd0, bus.alloc_id}, 64'd0);
    tick();
    check_eq("mr_cv_next", {62'd0, bus.commit_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
